lu_instr_issue: RTL
===================

# lu_instr_issue

Instruction issue buffer sitting directly upstream of `lu_processor`. It accepts 27-bit instruction words from a host over a valid/ready handshake and stores them in an internal FIFO. It issues at most one word per cycle on the processor's `VLD`/`INSTR_WORD` inputs. It also decodes a HALT command that freezes issue until the host resumes it, and counts issued instructions.

## Interface
- `INSTR_SIZE`, 27, instruction word width; must match the processor's `INTSR_SIZE`.
- `DEPTH`, 8, FIFO entries; power of two, minimum 2.
- `CNT_W`, 16, width of the issued-instruction counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `IN_VLD`  in  1  host word valid.
- `IN_INSTR`  in  INSTR_SIZE  host instruction word.
- `IN_RDY`  out  1  buffer can accept a word this cycle.
- `ISSUE_EN`  in  1  downstream permits issue this cycle.
- `RESUME`  in  1  single-cycle pulse that leaves the HALT state.
- `OUT_VLD`  out  1  registered; drives processor `VLD`.
- `OUT_INSTR`  out  INSTR_SIZE  registered; drives processor `INSTR_WORD`.
- `FIFO_COUNT`  out  $clog2(DEPTH)+1  current number of occupied entries.
- `FULL`  out  1  `FIFO_COUNT == DEPTH`.
- `EMPTY`  out  1  `FIFO_COUNT == 0`.
- `HALTED`  out  1  the state machine is in HALT.
- `ISSUED_CNT`  out  CNT_W  number of cycles with `OUT_VLD=1`; wraps modulo 2^CNT_W.

## Operation
- Command field is `IN_INSTR[26:24]`. The value 3'b111 is HALT; every other value is a normal instruction.
- Push: when `IN_VLD && IN_RDY`, the word is written at the write pointer and the write pointer increments, wrapping at DEPTH.
- `IN_RDY = !FULL`. It is combinational from the registered count. A pop in the same cycle does not free a slot for a push in that cycle.
- State machine, two states:
  - RUN (reset state).
  - HALT, indicated by `HALTED=1`.
- Pop condition: state is RUN, `ISSUE_EN=1` and `!EMPTY`. When the condition holds, the head entry is popped and the read pointer increments, wrapping at DEPTH.
  - Head is a normal instruction: on the next edge `OUT_VLD` goes to 1 and `OUT_INSTR` takes the head word.
  - Head is HALT: the word is consumed but not issued. `OUT_VLD` goes to 0 and the state moves to HALT.
- When the pop condition does not hold: `OUT_VLD` goes to 0 and `OUT_INSTR` holds its last value.
- HALT to RUN: on `RESUME=1`, effective on the next edge. Issue can restart on the cycle after that.
- `RESUME` in RUN has no effect.
- Pushes are still accepted while in HALT.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- `ISSUED_CNT` increments on every edge at which `OUT_VLD` is loaded with 1.

## Timing
- Reset values, visible after the first edge with `rst=1`:
  - `OUT_VLD=0`, `OUT_INSTR=0`.
  - `FIFO_COUNT=0`, `EMPTY=1`, `FULL=0`, `IN_RDY=1`.
  - `HALTED=0`, `ISSUED_CNT=0`.
  - Both pointers 0.
- Reset takes priority over every other input. Reset in mid-operation discards all buffered words and any pending HALT.
- Latency: a word accepted at edge k appears with `OUT_VLD=1` after edge k+1 at the earliest (two cycles from presentation). There is no bypass of an empty FIFO.
- Sustained throughput is one word per cycle when `ISSUE_EN=1` and the host streams continuously.
- FIFO contents are not cleared by reset. Only the pointers and count are reset.

## Test plan
- Reset, then push 0x0010203, 0x1040506 and 0x2070809 on consecutive cycles with `ISSUE_EN=1`:
  - `OUT_VLD=1` with the three words in order, starting two cycles after the first push.
  - `ISSUED_CNT=3` at the end.
- `ISSUE_EN=0`, push DEPTH=8 words:
  - `FULL=1`, `IN_RDY=0`.
  - A 9th word offered with `IN_VLD=1` is not stored and `FIFO_COUNT` stays 8.
  - Raise `ISSUE_EN`: 8 words issue in order and `EMPTY=1` afterwards.
- Push A=0x0000001, HALT=0x7000000, B=0x0000002:
  - A issues, then `HALTED=1` with `OUT_VLD=0` and B held.
  - Pulse `RESUME`: B issues two cycles after the pulse.
  - `ISSUED_CNT=2`.
- Pointer wrap: run 20 pushes and pops interleaved with random `ISSUE_EN`. The output order must equal the input order with no loss or duplication.
- Assert `rst` for one cycle while 5 words are buffered and `HALTED=1`:
  - Next cycle shows `FIFO_COUNT=0`, `HALTED=0`, `OUT_VLD=0`, `ISSUED_CNT=0`.
  - A new push issues normally.

Source files
------------

// File: rtl/lu_instr_issue.sv
// lu_instr_issue: instruction issue buffer in front of lu_processor.
// Host words enter a circular FIFO over a valid/ready handshake and leave
// at most one per cycle on registered OUT_VLD/OUT_INSTR. A HALT command
// word (top three bits all ones) is consumed silently and freezes issue
// until RESUME is pulsed. ISSUED_CNT counts cycles with OUT_VLD=1.
module lu_instr_issue #(
    parameter int INSTR_SIZE = 27,
    parameter int DEPTH      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_VLD,
    input  logic [INSTR_SIZE-1:0]      IN_INSTR,
    output logic                       IN_RDY,
    input  logic                       ISSUE_EN,
    input  logic                       RESUME,
    output logic                       OUT_VLD,
    output logic [INSTR_SIZE-1:0]      OUT_INSTR,
    output logic [$clog2(DEPTH):0]     FIFO_COUNT,
    output logic                       FULL,
    output logic                       EMPTY,
    output logic                       HALTED,
    output logic [CNT_W-1:0]           ISSUED_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);
    localparam logic [2:0] HALT_CMD = 3'b111;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Storage is deliberately left unreset; only pointers/count define
    // which entries are meaningful.
    logic [INSTR_SIZE-1:0] mem [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    state_t                state_reg;
    logic                  out_vld_reg;
    logic [INSTR_SIZE-1:0] out_instr_reg;
    logic [CNT_W-1:0]      issued_cnt_reg;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [INSTR_SIZE-1:0] head_word;
    logic                  head_is_halt;

    // Status is derived from the registered count only, so a pop in the
    // same cycle never opens a slot for a simultaneous push.
    assign full  = (count_reg == FULL_LVL);
    assign empty = (count_reg == '0);
    assign push  = IN_VLD && !full;
    assign pop   = (state_reg == ST_RUN) && ISSUE_EN && !empty;

    // The head must be decoded in the same cycle it is popped, so the
    // array is read asynchronously at the read pointer.
    assign head_word    = mem[rd_ptr_reg];
    assign head_is_halt = (head_word[INSTR_SIZE-1 -: 3] == HALT_CMD);

    // Write accepted host words into the slot under the write pointer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= IN_INSTR;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // RUN/HALT state machine with registered issue outputs and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            out_vld_reg    <= 1'b0;
            out_instr_reg  <= '0;
            issued_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pop) begin
                        if (head_is_halt) begin
                            // HALT words are swallowed, never issued.
                            out_vld_reg <= 1'b0;
                            state_reg   <= ST_HALT;
                        end else begin
                            out_vld_reg    <= 1'b1;
                            out_instr_reg  <= head_word;
                            issued_cnt_reg <= issued_cnt_reg + 1'b1;
                        end
                    end else begin
                        out_vld_reg <= 1'b0;
                    end
                end
                ST_HALT: begin
                    out_vld_reg <= 1'b0;
                    if (RESUME) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: begin
                    out_vld_reg <= 1'b0;
                    state_reg   <= ST_RUN;
                end
            endcase
        end
    end

    assign IN_RDY     = !full;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign FIFO_COUNT = count_reg;
    assign HALTED     = (state_reg == ST_HALT);
    assign OUT_VLD    = out_vld_reg;
    assign OUT_INSTR  = out_instr_reg;
    assign ISSUED_CNT = issued_cnt_reg;

endmodule
